// File: rtl/frame_deframer.sv
`default_nettype none
// frame_deframer: parses LSB-first serial frames {LEN, LEN payload bytes, CRC-16} from the
// sync-header demodulator and pulses fsc_end to send it back to header hunting.  Rev 1.0
module frame_deframer #(
  parameter int          MAX_LEN  = 64,
  parameter logic [15:0] CRC_POLY = 16'h1021,
  parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_in,
  input  logic       data_in_valid,
  output logic       fsc_end,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_start,
  output logic       frame_done,
  output logic       crc_ok,
  output logic       len_err
);

  typedef enum logic [2:0] {
    S_HUNT = 3'd0,
    S_LEN  = 3'd1,
    S_PAY  = 3'd2,
    S_CRC  = 3'd3,
    S_END  = 3'd4
  } state_t;

  localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);

  state_t      state, state_nx;
  logic [7:0]  shift_q, shift_nx;
  logic [2:0]  bit_cnt, bit_cnt_nx;
  logic [7:0]  byte_cnt, byte_cnt_nx;
  logic [7:0]  len_q, len_nx;
  logic [3:0]  crc_cnt, crc_cnt_nx;
  logic [15:0] crc_q, crc_nx;
  logic [15:0] rx_crc, rx_crc_nx;
  logic [7:0]  byte_out_nx;
  logic        fsc_end_nx, byte_valid_nx, frame_start_nx, frame_done_nx, crc_ok_nx, len_err_nx;
  logic        accept;
  logic [7:0]  assembled;
  logic [7:0]  byte_inc;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    crc_step = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? CRC_POLY : 16'h0000);
  endfunction

  // The bit offered during the END cycle is dropped on purpose.
  assign accept    = data_in_valid && (state != S_END);
  assign assembled = {data_in, shift_q[7:1]};
  assign byte_inc  = byte_cnt + 8'd1;

  always_comb begin
    state_nx       = state;
    shift_nx       = shift_q;
    bit_cnt_nx     = bit_cnt;
    byte_cnt_nx    = byte_cnt;
    len_nx         = len_q;
    crc_cnt_nx     = crc_cnt;
    crc_nx         = crc_q;
    rx_crc_nx      = rx_crc;
    byte_out_nx    = byte_out;
    fsc_end_nx     = 1'b0;
    byte_valid_nx  = 1'b0;
    frame_start_nx = 1'b0;
    frame_done_nx  = 1'b0;
    crc_ok_nx      = 1'b0;
    len_err_nx     = 1'b0;
    case (state)
      S_HUNT: begin
        if (accept) begin
          shift_nx   = assembled;
          bit_cnt_nx = 3'd1;
          crc_nx     = crc_step(CRC_INIT, data_in);
          state_nx   = S_LEN;
        end
      end
      S_LEN: begin
        if (accept) begin
          shift_nx   = assembled;
          bit_cnt_nx = bit_cnt + 3'd1;
          crc_nx     = crc_step(crc_q, data_in);
          if (bit_cnt == 3'd7) begin
            if ((assembled != 8'd0) && ({1'b0, assembled} <= MAX_LEN_W)) begin
              len_nx         = assembled;
              byte_cnt_nx    = 8'd0;
              frame_start_nx = 1'b1;
              state_nx       = S_PAY;
            end else begin
              len_err_nx = 1'b1;
              fsc_end_nx = 1'b1;
              state_nx   = S_END;
            end
          end
        end
      end
      S_PAY: begin
        if (accept) begin
          shift_nx   = assembled;
          bit_cnt_nx = bit_cnt + 3'd1;
          crc_nx     = crc_step(crc_q, data_in);
          if (bit_cnt == 3'd7) begin
            byte_out_nx   = assembled;
            byte_valid_nx = 1'b1;
            byte_cnt_nx   = byte_inc;
            if (byte_inc == len_q) begin
              crc_cnt_nx = 4'd0;
              state_nx   = S_CRC;
            end
          end
        end
      end
      S_CRC: begin
        if (accept) begin
          rx_crc_nx  = {rx_crc[14:0], data_in};
          crc_cnt_nx = crc_cnt + 4'd1;
          if (crc_cnt == 4'd15) begin
            fsc_end_nx    = 1'b1;
            frame_done_nx = 1'b1;
            crc_ok_nx     = (rx_crc_nx == crc_q);
            state_nx      = S_END;
          end
        end
      end
      S_END:   state_nx = S_HUNT;
      default: state_nx = S_HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_HUNT;
      shift_q     <= 8'd0;
      bit_cnt     <= 3'd0;
      byte_cnt    <= 8'd0;
      len_q       <= 8'd0;
      crc_cnt     <= 4'd0;
      crc_q       <= CRC_INIT;
      rx_crc      <= 16'd0;
      byte_out    <= 8'd0;
      fsc_end     <= 1'b0;
      byte_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      crc_ok      <= 1'b0;
      len_err     <= 1'b0;
    end else begin
      state       <= state_nx;
      shift_q     <= shift_nx;
      bit_cnt     <= bit_cnt_nx;
      byte_cnt    <= byte_cnt_nx;
      len_q       <= len_nx;
      crc_cnt     <= crc_cnt_nx;
      crc_q       <= crc_nx;
      rx_crc      <= rx_crc_nx;
      byte_out    <= byte_out_nx;
      fsc_end     <= fsc_end_nx;
      byte_valid  <= byte_valid_nx;
      frame_start <= frame_start_nx;
      frame_done  <= frame_done_nx;
      crc_ok      <= crc_ok_nx;
      len_err     <= len_err_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_deframer.sv
`default_nettype none
// Scoreboard bench for frame_deframer: directed and random frames checked against a frame-level model.
module tb_frame_deframer;

  localparam int MAX_LEN = 64;
  localparam int K_FS    = 0;
  localparam int K_BYTE  = 1;
  localparam int K_LERR  = 2;
  localparam int K_DONE  = 3;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       data_in = 1'b0;
  logic       data_in_valid = 1'b0;
  logic       fsc_end, byte_valid, frame_start, frame_done, crc_ok, len_err;
  logic [7:0] byte_out;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t expq[$];
  logic [7:0] pay_buf [0:255];

  frame_deframer #(.MAX_LEN(MAX_LEN), .CRC_POLY(16'h1021), .CRC_INIT(16'hFFFF)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
    .fsc_end(fsc_end), .byte_out(byte_out), .byte_valid(byte_valid),
    .frame_start(frame_start), .frame_done(frame_done), .crc_ok(crc_ok), .len_err(len_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  task automatic expect_event(input int kind, input logic [7:0] data, input string name);
    exp_t e;
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $display("FAIL %s: pulse at cycle %0d data=%02h, required no pulse", name, cyc, data);
    end else begin
      e = expq.pop_front();
      if (e.kind != kind || e.data != data || e.cyc != cyc) begin
        errors++;
        $display("FAIL %s: got kind=%0d data=%02h cycle=%0d, required kind=%0d data=%02h cycle=%0d",
                 name, kind, data, cyc, e.kind, e.data, e.cyc);
      end
    end
  endtask

  // Monitor: every output pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst) begin
      if (frame_start) expect_event(K_FS, 8'h00, "frame_start");
      if (byte_valid)  expect_event(K_BYTE, byte_out, "byte_valid");
      if (len_err)     expect_event(K_LERR, {7'd0, fsc_end & ~frame_done}, "len_err");
      if (frame_done)  expect_event(K_DONE, {6'd0, fsc_end, crc_ok}, "frame_done");
      if ((fsc_end && !frame_done && !len_err) || (crc_ok && !frame_done)) begin
        checks++;
        errors++;
        $display("FAIL stray_pulse: fsc_end=%b crc_ok=%b frame_done=%b len_err=%b at cycle %0d, required fsc_end/crc_ok only with frame_done or len_err",
                 fsc_end, crc_ok, frame_done, len_err, cyc);
      end
    end
  end

  // Builds the frame bit stream, pushes the expected pulse for each completing bit, drives it.
  task automatic send_frame(input int len, input int flip, input int gmin, input int gmax,
                            input int stop_at, input bit junk_tail);
    logic        bits[$];
    logic [15:0] c_tx, c_rx;
    logic [7:0]  lb, cur, mask;
    bit          legal;
    int          npay, nbits, bidx;
    exp_t        e;
    lb    = 8'(len);
    legal = (len >= 1) && (len <= MAX_LEN);
    npay  = legal ? len : 0;
    for (int i = 0; i < 8; i++) bits.push_back(lb[i]);
    for (int b = 0; b < npay; b++) begin
      cur = pay_buf[b];
      for (int i = 0; i < 8; i++) bits.push_back(cur[i]);
    end
    c_tx = 16'hFFFF;
    foreach (bits[i]) c_tx = crc_bit(c_tx, bits[i]);
    if (legal && flip >= 0) bits[8 + flip] = ~bits[8 + flip];
    c_rx = 16'hFFFF;
    foreach (bits[i]) c_rx = crc_bit(c_rx, bits[i]);
    if (legal) for (int i = 15; i >= 0; i--) bits.push_back(c_tx[i]);
    nbits = (stop_at >= 0 && stop_at < bits.size()) ? stop_at : bits.size();
    for (int k = 0; k < nbits; k++) begin
      if (k > 0) begin
        repeat ($urandom_range(gmax, gmin)) begin
          @(posedge clk); #1;
          data_in_valid = 1'b0;
          data_in       = 1'($urandom);
        end
      end
      @(posedge clk); #1;
      data_in       = bits[k];
      data_in_valid = 1'b1;
      e.cyc = cyc + 1;
      if (k == 7) begin
        e.kind = legal ? K_FS : K_LERR;
        e.data = legal ? 8'h00 : 8'h01;
        expq.push_back(e);
      end else if (legal && k >= 8 && k < 8 + 8 * len && (k - 8) % 8 == 7) begin
        bidx   = (k - 8) / 8;
        mask   = (flip >= 0 && flip / 8 == bidx) ? 8'(1 << (flip % 8)) : 8'h00;
        e.kind = K_BYTE;
        e.data = pay_buf[bidx] ^ mask;
        expq.push_back(e);
      end else if (legal && k == bits.size() - 1) begin
        e.kind = K_DONE;
        e.data = {6'd0, 1'b1, (c_rx == c_tx)};
        expq.push_back(e);
      end
    end
    @(posedge clk); #1;
    if (junk_tail) begin
      data_in       = 1'($urandom);
      data_in_valid = 1'b1;
    end else begin
      data_in_valid = 1'b0;
    end
  endtask

  task automatic finish_frame(input string name);
    @(posedge clk); #1;
    data_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected pulses still pending, required 0", name, expq.size());
      expq.delete();
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({fsc_end, byte_out, byte_valid, frame_start, frame_done, crc_ok, len_err} !== 14'd0) begin
      errors++;
      $display("FAIL %s: outputs fsc_end=%b byte_out=%02h byte_valid=%b frame_start=%b frame_done=%b crc_ok=%b len_err=%b, required all 0",
               name, fsc_end, byte_out, byte_valid, frame_start, frame_done, crc_ok, len_err);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    @(negedge clk);
    rst = 1'b1;

    pay_buf[0] = 8'h01; pay_buf[1] = 8'h80; pay_buf[2] = 8'hFF;
    send_frame(3, -1, 0, 0, -1, 1'b0);
    finish_frame("good_frame");
    send_frame(3, 9, 0, 0, -1, 1'b0);
    finish_frame("corrupt_crc");

    send_frame(0, -1, 0, 0, -1, 1'b0);
    finish_frame("len_zero");
    send_frame(65, -1, 0, 0, -1, 1'b0);
    finish_frame("len_65");

    pay_buf[0] = 8'h5A;
    send_frame(1, -1, 0, 0, -1, 1'b0);
    finish_frame("no_gaps");
    send_frame(1, -1, 3, 3, -1, 1'b0);
    finish_frame("valid_gaps");

    pay_buf[0] = 8'h3C;
    send_frame(1, -1, 0, 0, -1, 1'b1);
    pay_buf[0] = 8'h77;
    send_frame(1, -1, 0, 0, -1, 1'b0);
    finish_frame("back_to_back");

    // Abort while the first payload byte strobe is on the outputs.
    pay_buf[0] = 8'hA5; pay_buf[1] = 8'h3C;
    send_frame(2, -1, 0, 0, 16, 1'b0);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    check_all_zero("reset_mid_pay");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    send_frame(2, -1, 0, 0, -1, 1'b0);
    finish_frame("after_reset");

    for (int n = 0; n < 25; n++) begin
      int rl, rf, r;
      r  = $urandom_range(9, 0);
      rl = (r == 0) ? 0 : (r == 1) ? int'($urandom_range(255, 65)) : int'($urandom_range(8, 1));
      for (int b = 0; b < 8; b++) pay_buf[b] = 8'($urandom);
      rf = -1;
      if (rl >= 1 && rl <= 8 && $urandom_range(2, 0) == 0) rf = int'($urandom_range(8 * rl - 1, 0));
      send_frame(rl, rf, 0, int'($urandom_range(2, 0)), -1, 1'($urandom_range(1, 0)));
      finish_frame("random_frame");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
